// File: rtl/shift_add_mul_seq_pkg.sv
// Shared ALU definitions for the shift-and-add multiply sequencer:
// state encodings, default operand width and product width.
package shift_add_mul_seq_pkg;

    localparam int L_DEF  = 16;
    localparam int PROD_W = 2 * L_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FIX  = 2'd3
    } mul_state_t;

endpackage

// File: rtl/shift_add_mul_seq.sv
// Iterative shift-and-add multiplier that borrows the ALU's external adder
// through the AddA/AddB/AddS/AddCarry ports. One partial product per RUN cycle.
// Optional build macro SHIFT_ADD_MUL_SIGNED_EN adds a Signed input and a FIX
// state that restores the sign of a two's-complement product.
//
//   state | meaning
//   IDLE  | waiting for Start; adder operands forced to zero
//   RUN   | one add-and-shift per cycle, L cycles
//   FIX   | (signed build only) negate product when operand signs differ
//   DONE  | latch product; Done/Busy reported on the following cycle
module shift_add_mul_seq
    import shift_add_mul_seq_pkg::*;
#(
    parameter int L  = L_DEF,
    parameter int CW = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [L-1:0]     Multiplicand,
    input  logic [L-1:0]     Multiplier,
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    input  logic             Signed,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [2*L-1:0]   Product,
    output logic [L-1:0]     AddA,
    output logic [L-1:0]     AddB,
    input  logic [L-1:0]     AddS,
    input  logic             AddCarry
);

    mul_state_t       state, state_nxt;
    logic [2*L-1:0]   p_reg;
    logic [L-1:0]     m_reg;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;
    logic [2*L-1:0]   product_r;
    logic [L-1:0]     m_mag;
    logic [L-1:0]     q_mag;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    logic             neg_in;
    logic             neg_r;
`endif

    // Operand magnitudes presented at capture; signed operands are negated locally.
    always_comb begin
        m_mag = Multiplicand;
        q_mag = Multiplier;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
        neg_in = Signed & (Multiplicand[L-1] ^ Multiplier[L-1]);
        if (Signed && Multiplicand[L-1]) m_mag = ~Multiplicand + 1'b1;
        if (Signed && Multiplier[L-1])   q_mag = ~Multiplier + 1'b1;
`endif
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and adder operand steering.
    always_comb begin
        state_nxt = state;
        AddA      = '0;
        AddB      = '0;
        case (state)
            ST_IDLE: if (Start) state_nxt = ST_RUN;
            ST_RUN: begin
                AddA = p_reg[2*L-1:L];
                AddB = p_reg[0] ? m_reg : '0;
                if (cnt == CW'(L-1)) begin
`ifdef SHIFT_ADD_MUL_SIGNED_EN
                    state_nxt = ST_FIX;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef SHIFT_ADD_MUL_SIGNED_EN
            ST_FIX:  state_nxt = ST_DONE;
`endif
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, add-and-shift, sign fix, result latch.
    // Done and Busy are registered, so the Done cycle follows the DONE state;
    // a Start presented during that cycle is already accepted from IDLE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            p_reg     <= '0;
            m_reg     <= '0;
            cnt       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
            neg_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (done_r) busy_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        p_reg  <= {{L{1'b0}}, q_mag};
                        m_reg  <= m_mag;
                        cnt    <= '0;
                        busy_r <= 1'b1;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
                        neg_r  <= neg_in;
`endif
                    end
                end
                ST_RUN: begin
                    p_reg <= {AddCarry, AddS, p_reg[L-1:1]};
                    cnt   <= cnt + 1'b1;
                end
`ifdef SHIFT_ADD_MUL_SIGNED_EN
                ST_FIX: begin
                    if (neg_r) p_reg <= ~p_reg + 1'b1;
                end
`endif
                ST_DONE: begin
                    product_r <= p_reg;
                    done_r    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Busy    = busy_r;
    assign Done    = done_r;
    assign Product = product_r;

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Randomised self-checking bench for shift_add_mul_seq with a behavioural
// adder on the AddA/AddB/AddS/AddCarry ports and an arithmetic reference model.
// Honours SHIFT_ADD_MUL_SIGNED_EN when the build defines it.
module tb_shift_add_mul_seq;
    import shift_add_mul_seq_pkg::*;

    localparam int L = L_DEF;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    localparam int LAT = L + 2;
`else
    localparam int LAT = L + 1;
`endif

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic [L-1:0]      Multiplicand = '0;
    logic [L-1:0]      Multiplier = '0;
    logic              sgn_in = 1'b0;
    logic              Busy, Done;
    logic [PROD_W-1:0] Product;
    logic [L-1:0]      AddA, AddB, AddS;
    logic              AddCarry;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    assign {AddCarry, AddS} = {1'b0, AddA} + {1'b0, AddB};

    shift_add_mul_seq #(.L(L), .CW(5)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
`ifdef SHIFT_ADD_MUL_SIGNED_EN
        .Signed       (sgn_in),
`endif
        .Busy         (Busy),
        .Done         (Done),
        .Product      (Product),
        .AddA         (AddA),
        .AddB         (AddB),
        .AddS         (AddS),
        .AddCarry     (AddCarry)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PROD_W-1:0] ref_mul(input logic [L-1:0] m, input logic [L-1:0] q,
                                                   input logic sgn);
        longint a, b;
        if (sgn) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
        end else begin
            a = longint'(m);
            b = longint'(q);
        end
        return PROD_W'(a * b);
    endfunction

    // One operation from an idle DUT. inject_at >= 0 pulses Start with junk
    // operands during that RUN cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [L-1:0] m, input logic [L-1:0] q,
                          input logic sgn, input int inject_at);
        logic [PROD_W-1:0] exp_p;
        int n;
        int bad_b;
        bit got;
        exp_p = ref_mul(m, q, sgn);
        @(negedge Clk);
        Start = 1'b1; Multiplicand = m; Multiplier = q; sgn_in = sgn;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        check_eq({tag, "_busy"}, 64'(Busy), 64'd1);
        n = 0; bad_b = 0; got = 1'b0;
        while (n < 3 * LAT && !got) begin
            if (n == inject_at) begin
                Start = 1'b1;
                Multiplicand = L'($urandom);
                Multiplier = L'($urandom);
            end else begin
                Start = 1'b0;
            end
            if (n < L && !sgn && AddB !== (q[n] ? m : '0)) bad_b++;
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (Done) got = 1'b1;
        end
        Start = 1'b0;
        check_eq({tag, "_latency"}, 64'(n), 64'(LAT));
        check_eq({tag, "_product"}, 64'(Product), 64'(exp_p));
        if (!sgn) check_eq({tag, "_addb_seq"}, 64'(bad_b), 64'd0);
        @(negedge Clk);
        check_eq({tag, "_done_pulse"}, 64'(Done), 64'd0);
        check_eq({tag, "_idle_busy"}, 64'(Busy), 64'd0);
        check_eq({tag, "_held"}, 64'(Product), 64'(exp_p));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [L-1:0] mb [4];
        logic [L-1:0] qb [4];
        int n;
        int done_seen;
        bit got;

        // reset state
        repeat (3) @(negedge Clk);
        check_eq("rst_busy", 64'(Busy), 64'd0);
        check_eq("rst_done", 64'(Done), 64'd0);
        check_eq("rst_product", 64'(Product), 64'd0);
        check_eq("rst_adda", 64'(AddA), 64'd0);
        check_eq("rst_addb", 64'(AddB), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("idle_adda", 64'(AddA), 64'd0);

        // directed cases
        run_op("m3q5", 16'd3, 16'd5, 1'b0, -1);
        check_eq("m3q5_const", 64'(Product), 64'h0000000F);
        run_op("ffff", 16'hFFFF, 16'hFFFF, 1'b0, -1);
        check_eq("ffff_const", 64'(Product), 64'hFFFE0001);
        run_op("zero_m", 16'h0000, 16'h1234, 1'b0, -1);
        run_op("zero_q", 16'h1234, 16'h0000, 1'b0, -1);

        // Start during RUN is ignored; the following Start is accepted
        run_op("ignore", 16'd3, 16'd5, 1'b0, 5);
        check_eq("ignore_const", 64'(Product), 64'h0000000F);
        run_op("after_ignore", 16'hBEEF, 16'h0042, 1'b0, -1);

        // reset mid-operation
        @(negedge Clk);
        Start = 1'b1; Multiplicand = 16'h1357; Multiplier = 16'h2468;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (8) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_eq("midrst_busy", 64'(Busy), 64'd0);
        check_eq("midrst_done", 64'(Done), 64'd0);
        check_eq("midrst_product", 64'(Product), 64'd0);
        check_eq("midrst_adda", 64'(AddA), 64'd0);
        check_eq("midrst_addb", 64'(AddB), 64'd0);
        done_seen = 0;
        repeat (2 * LAT) begin
            @(negedge Clk);
            if (Done) done_seen++;
        end
        check_eq("midrst_no_done", 64'(done_seen), 64'd0);
        run_op("m7q9", 16'd7, 16'd9, 1'b0, -1);
        check_eq("m7q9_const", 64'(Product), 64'h0000003F);

        // Start held high: one result every LAT+1 cycles
        for (int i = 0; i < 4; i++) begin
            mb[i] = L'($urandom);
            qb[i] = L'($urandom);
        end
        @(negedge Clk);
        Start = 1'b1; sgn_in = 1'b0; Multiplicand = mb[0]; Multiplier = qb[0];
        @(posedge Clk);
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            n = 0; got = 1'b0;
            while (n < 3 * LAT && !got) begin
                @(posedge Clk);
                n++;
                @(negedge Clk);
                if (Done) got = 1'b1;
            end
            check_eq($sformatf("b2b%0d_gap", i), 64'(n), 64'((i == 0) ? LAT : LAT + 1));
            check_eq($sformatf("b2b%0d_product", i), 64'(Product), 64'(ref_mul(mb[i], qb[i], 1'b0)));
            if (i < 3) begin
                Multiplicand = mb[i+1];
                Multiplier = qb[i+1];
            end else begin
                Start = 1'b0;
            end
        end
        @(negedge Clk);
        @(negedge Clk);
        check_eq("b2b_stop_busy", 64'(Busy), 64'd0);

        // random unsigned operations
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("rnd%0d", i), L'($urandom), L'($urandom), 1'b0, -1);
        end

`ifdef SHIFT_ADD_MUL_SIGNED_EN
        run_op("s_m3q5", 16'hFFFD, 16'd5, 1'b1, -1);
        check_eq("s_m3q5_const", 64'(Product), 64'hFFFFFFF1);
        run_op("s_min", 16'h8000, 16'h8000, 1'b1, -1);
        check_eq("s_min_const", 64'(Product), 64'h40000000);
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("srnd%0d", i), L'($urandom), L'($urandom), 1'b1, -1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
